// File: rtl/pc_fetch_unit_pkg.sv
// Shared PC package: PC width, branch-select encodings, fetch states.
// Imported by the fetch unit and its pending-redirect latch.
package pc_fetch_unit_pkg;

  localparam int PC_W = 64;

  // Next-PC select codes driven by the branch-source stage.
  localparam logic [1:0] PCPLUS4  = 2'd0;
  localparam logic [1:0] PCBRANCH = 2'd1;
  localparam logic [1:0] PCALUOUT = 2'd2;

  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

  function automatic logic [PC_W-1:0] align4(
    input logic [PC_W-1:0] a
  );
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_redirect_latch.sv
// pc_redirect_latch: holds one redirect target that arrived while a
// fetch was outstanding. Ports: clk, reset, load, clear, target in; valid, target_q out.
module pc_redirect_latch
  import pc_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] target,
  output logic            valid,
  output logic [PC_W-1:0] target_q
);

  // A newer redirect always replaces an older one.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      target_q <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      target_q <= target;
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: owns the PC, issues instruction-memory requests, applies
// redirects. Ports: branch bundle in, stall in, imem req/addr/ready, instr report, link, fault.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  branch,
  input  logic        branch_valid,
  input  logic [63:0] branch_target,
  input  logic [63:0] alu_out,
  input  logic [63:0] branch_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic [63:0] instr_pc,
  output logic [63:0] link_addr,
  output logic        misalign_fault
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            pend_valid;
  logic [PC_W-1:0] pend_target;
  logic            redirect;
  logic [PC_W-1:0] raw_target;
  logic [PC_W-1:0] target;
  logic            accept;

  assign redirect = branch_valid &&
                    (branch == PCBRANCH || branch == PCALUOUT);
  assign raw_target = (branch == PCALUOUT) ? alu_out
                                           : branch_target;
  assign target = align4(raw_target);

  // Reset gates the request so a pending one is abandoned at once.
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      RST_WAIT: imem_req = 1'b0;
      FETCH:    imem_req = ~stall;
      WAIT:     imem_req = 1'b1;
      HOLD:     imem_req = 1'b0;
    endcase
    imem_req = imem_req & ~reset;
  end

  assign accept    = imem_req & imem_ready;
  assign imem_addr = pc;

  pc_redirect_latch u_latch (
    .clk      (clk),
    .reset    (reset),
    .load     (state == WAIT && !accept && redirect),
    .clear    (state == WAIT && accept),
    .target   (target),
    .valid    (pend_valid),
    .target_q (pend_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RST_WAIT;
      pc             <= RESET_VECTOR;
      instr_valid    <= 1'b0;
      instr_pc       <= '0;
      link_addr      <= '0;
      misalign_fault <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      if (branch_valid && branch == PCBRANCH)
        link_addr <= branch_pc + 64'd4;
      if (redirect && raw_target[1:0] != 2'b00)
        misalign_fault <= 1'b1;
      unique case (state)
        RST_WAIT: begin
          state <= FETCH;
          if (redirect) pc <= target;
        end
        FETCH: begin
          // A same-cycle redirect squashes the accepted fetch.
          if (redirect) begin
            pc <= target;
          end else if (accept) begin
            pc          <= pc + 64'd4;
            instr_valid <= 1'b1;
            instr_pc    <= pc;
          end
          if (stall)            state <= HOLD;
          else if (!imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (accept) begin
            state <= FETCH;
            if (redirect) begin
              pc <= target;
            end else if (pend_valid) begin
              pc <= pend_target;
            end else begin
              pc          <= pc + 64'd4;
              instr_valid <= 1'b1;
              instr_pc    <= pc;
            end
          end
        end
        HOLD: begin
          if (redirect) pc    <= target;
          if (!stall)   state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic,
// scored against a behavioural model with a queue of expected reports.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [63:0] RV = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  branch = '0;
  logic        branch_valid = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] alu_out = '0;
  logic [63:0] branch_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        instr_valid;
  logic [63:0] instr_pc;
  logic [63:0] link_addr;
  logic        misalign_fault;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .branch         (branch),
    .branch_valid   (branch_valid),
    .branch_target  (branch_target),
    .alu_out        (alu_out),
    .branch_pc      (branch_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .link_addr      (link_addr),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [63:0] exp_q[$];

  // Model: a PC plus a few flags describing what the unit is doing.
  logic [63:0] m_pc = RV;
  logic [63:0] m_pend = '0;
  logic [63:0] m_link = '0;
  bit m_pv, m_fault, m_boot = 1'b1, m_wait, m_hold;

  function automatic bit m_req();
    return !reset && !m_boot && !m_hold && (m_wait || !stall);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  bit          acc, redir;
  logic [63:0] raw, tgt;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RV; m_pend = '0; m_link = '0;
      m_pv = 0; m_fault = 0; m_boot = 1; m_wait = 0; m_hold = 0;
      exp_q.delete();
    end else begin
      acc   = m_req() && imem_ready;
      redir = branch_valid && (branch == 2'd1 || branch == 2'd2);
      raw   = (branch == 2'd2) ? alu_out : branch_target;
      tgt   = raw & ~64'h3;
      if (branch_valid && branch == 2'd1) m_link = branch_pc + 4;
      if (redir && raw[1:0] != 0) m_fault = 1;
      if (m_boot) begin
        m_boot = 0;
        if (redir) m_pc = tgt;
      end else if (m_wait) begin
        if (acc) begin
          m_wait = 0;
          if (redir) m_pc = tgt;
          else if (m_pv) m_pc = m_pend;
          else begin exp_q.push_back(m_pc); m_pc = m_pc + 4; end
          m_pv = 0;
        end else if (redir) begin
          m_pend = tgt; m_pv = 1;
        end
      end else if (m_hold) begin
        if (redir) m_pc = tgt;
        if (!stall) m_hold = 0;
      end else begin
        if (redir) m_pc = tgt;
        else if (acc) begin exp_q.push_back(m_pc); m_pc = m_pc + 4; end
        if (stall) m_hold = 1;
        else if (!imem_ready) m_wait = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("imem_req", imem_req, m_req());
      chk("imem_addr", imem_addr, m_pc);
      chk("link_addr", link_addr, m_link);
      chk("misalign_fault", misalign_fault, m_fault);
      if (instr_valid) begin
        if (exp_q.size() == 0) chk("instr_valid", instr_valid, 0);
        else chk("instr_pc", instr_pc, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        chk("instr_valid", instr_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit r, input bit st, input bit rdy,
                      input bit bv, input logic [1:0] br,
                      input logic [63:0] bt, input logic [63:0] alu,
                      input logic [63:0] bpc);
    @(posedge clk);
    #1;
    reset = r; stall = st; imem_ready = rdy;
    branch_valid = bv; branch = br;
    branch_target = bt; alu_out = alu; branch_pc = bpc;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input bit st, input bit rdy);
    step(r, st, rdy, 0, PCPLUS4, 0, 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(1, 0, 0);
    idle(1, 0, 0);
    mon_en = 1'b1;
    chk("rst req", imem_req, 0);
    chk("rst addr", imem_addr, RV);
    chk("rst valid", instr_valid, 0);
    chk("rst link", link_addr, 0);
    chk("rst fault", misalign_fault, 0);
    // Boot and sequential fetch.
    idle(0, 0, 1);
    chk("boot req", imem_req, 0);
    idle(0, 0, 1);
    chk("seq addr0", imem_addr, 64'h0);
    idle(0, 0, 1);
    chk("seq addr4", imem_addr, 64'h4);
    chk("seq ipc0", instr_pc, 64'h0);
    step(0, 0, 1, 1, PCBRANCH, 64'h100, 0, 64'h8);
    chk("seq addr8", imem_addr, 64'h8);
    chk("seq ipc4", instr_pc, 64'h4);
    // Redirect wins over the accept of 0x8.
    step(0, 0, 1, 1, PCALUOUT, 0, 64'hC, 0);
    chk("br addr", imem_addr, 64'h100);
    chk("br squash", instr_valid, 0);
    chk("br link", link_addr, 64'hC);
    // Redirects while waiting at 0xC go pending; the last one wins.
    idle(0, 0, 0);
    chk("wait0 addr", imem_addr, 64'hC);
    step(0, 0, 0, 1, PCALUOUT, 0, 64'h200, 0);
    chk("wait1 addr", imem_addr, 64'hC);
    step(0, 0, 0, 1, PCBRANCH, 64'h300, 0, 64'h20);
    chk("wait2 addr", imem_addr, 64'hC);
    idle(0, 0, 1);
    chk("wait3 addr", imem_addr, 64'hC);
    chk("wait3 req", imem_req, 1);
    // Stall from FETCH for four cycles.
    for (int i = 0; i < 4; i++) begin
      idle(0, 1, 1);
      chk("stall req", imem_req, 0);
      chk("stall addr", imem_addr, 64'h300);
      chk("stall squash", instr_valid, 0);
    end
    idle(0, 0, 1);
    chk("hold exit req", imem_req, 0);
    idle(0, 0, 0);
    chk("refetch req", imem_req, 1);
    idle(0, 1, 0);
    chk("wait stall req", imem_req, 1);
    chk("wait stall addr", imem_addr, 64'h300);
    idle(0, 1, 1);
    chk("wait stall acc", imem_req, 1);
    // Misaligned PC-relative target.
    step(0, 0, 1, 1, PCBRANCH, 64'h102, 0, 64'h40);
    chk("ipc 300", instr_pc, 64'h300);
    idle(0, 0, 0);
    chk("mis addr", imem_addr, 64'h100);
    chk("mis fault", misalign_fault, 1);
    chk("mis link", link_addr, 64'h44);
    // Reset while waiting.
    idle(1, 0, 0);
    chk("rstw req", imem_req, 0);
    idle(0, 0, 1);
    chk("rstw req2", imem_req, 0);
    chk("rstw addr", imem_addr, RV);
    chk("rstw valid", instr_valid, 0);
    chk("rstw fault", misalign_fault, 0);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] bt, alu;
      bt  = {32'h0, $urandom} & 64'hFFFF_FFFC;
      alu = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) alu = alu & ~64'h3;
      if ($urandom_range(0, 9) == 0) bt = bt | 64'h2;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)),
           bt, alu, {$urandom, $urandom});
    end
    idle(0, 0, 1);
    idle(0, 0, 1);
    chk("queue drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
